// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, bridge FSM states and the register-window helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RESP,
    RD_ACC,
    RD_RESP
  } bridge_state_t;

  // True when no address bit at or above the register window is set.
  function automatic logic addr_in_window(input logic [31:0] addr, input int unsigned width);
    return (addr >> width) == 32'd0;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: 32-bit address/data, 2-bit responses, no strobes or protection bits.
interface axi_lite_if;

  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axil_access_timer.sv
// Register-access watchdog: loads on the access strobe, stops on ack, flags expiry
// in the last cycle of the TIMEOUT_CYCLES window that starts with the strobe cycle.
module axil_access_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  // The strobe cycle itself is the first cycle of the window, hence the -2.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;
  logic          running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (clear) begin
      running <= 1'b0;
    end else if (load) begin
      count   <= LOAD_VAL;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/axi_lite_if_reg_bridge.sv
// AXI4-Lite slave to single-word register bus with variable-latency ack.
// Optional access timeout enabled by defining AXIL_REG_TIMEOUT_EN.
module axi_lite_if_reg_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      axil_aclk,
  input  logic                      axil_rst,
  axi_lite_if.slave                 s_axil,
  output logic                      reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [31:0]               reg_wr_data,
  input  logic                      reg_wr_ack,
  output logic                      reg_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [31:0]               reg_rd_data,
  input  logic                      reg_rd_ack
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  bridge_state_t state;
  logic          wr_first;
  logic          aw_full, w_full, ar_full;
  logic [31:0]   aw_addr_q, w_data_q, ar_addr_q;
  logic          aw_hs, w_hs, ar_hs, wr_done, rd_done;
  logic          wr_req, rd_req, grant_wr, grant_rd;
  logic [31:0]   aw_addr_cur, w_data_cur, ar_addr_cur;
  logic          timer_expired;

  assign aw_hs   = s_axil.aw_valid && s_axil.aw_ready;
  assign w_hs    = s_axil.w_valid  && s_axil.w_ready;
  assign ar_hs   = s_axil.ar_valid && s_axil.ar_ready;
  assign wr_done = (state == WR_RESP) && s_axil.b_valid && s_axil.b_ready;
  assign rd_done = (state == RD_RESP) && s_axil.r_valid && s_axil.r_ready;

  // A handshake in the current cycle counts as buffered so the strobe follows one cycle later.
  assign aw_addr_cur = aw_full ? aw_addr_q : s_axil.aw_addr;
  assign w_data_cur  = w_full  ? w_data_q  : s_axil.w_data;
  assign ar_addr_cur = ar_full ? ar_addr_q : s_axil.ar_addr;
  assign wr_req      = (aw_full || aw_hs) && (w_full || w_hs);
  assign rd_req      = ar_full || ar_hs;
  assign grant_wr    = wr_req && (wr_first || !rd_req);
  assign grant_rd    = rd_req && !grant_wr;

`ifdef AXIL_REG_TIMEOUT_EN
  logic timer_clear;
  assign timer_clear = ((state == WR_ACC) && reg_wr_ack) || ((state == RD_ACC) && reg_rd_ack);

  axil_access_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (axil_aclk),
    .rst     (axil_rst),
    .load    (reg_wr_en || reg_rd_en),
    .clear   (timer_clear),
    .expired (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge axil_aclk) begin
    if (aw_hs) aw_addr_q <= s_axil.aw_addr;
    if (w_hs)  w_data_q  <= s_axil.w_data;
    if (ar_hs) ar_addr_q <= s_axil.ar_addr;
  end

  // Holding buffers stay occupied until the matching response handshake.
  always_ff @(posedge axil_aclk or posedge axil_rst) begin
    if (axil_rst) begin
      aw_full         <= 1'b0;
      w_full          <= 1'b0;
      ar_full         <= 1'b0;
      s_axil.aw_ready <= 1'b0;
      s_axil.w_ready  <= 1'b0;
      s_axil.ar_ready <= 1'b0;
    end else begin
      aw_full         <= aw_hs || (aw_full && !wr_done);
      w_full          <= w_hs  || (w_full  && !wr_done);
      ar_full         <= ar_hs || (ar_full && !rd_done);
      s_axil.aw_ready <= !(aw_hs || (aw_full && !wr_done));
      s_axil.w_ready  <= !(w_hs  || (w_full  && !wr_done));
      s_axil.ar_ready <= !(ar_hs || (ar_full && !rd_done));
    end
  end

  always_ff @(posedge axil_aclk or posedge axil_rst) begin
    if (axil_rst) begin
      state          <= IDLE;
      wr_first       <= 1'b1;
      reg_wr_en      <= 1'b0;
      reg_wr_addr    <= '0;
      reg_wr_data    <= '0;
      reg_rd_en      <= 1'b0;
      reg_rd_addr    <= '0;
      s_axil.b_valid <= 1'b0;
      s_axil.b_resp  <= RESP_OKAY;
      s_axil.r_valid <= 1'b0;
      s_axil.r_resp  <= RESP_OKAY;
      s_axil.r_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Priority only flips when both directions contend.
          if (wr_req && rd_req) wr_first <= !wr_first;
          if (grant_wr) begin
            if (addr_in_window(aw_addr_cur, REG_ADDR_WIDTH)) begin
              state       <= WR_ACC;
              reg_wr_en   <= 1'b1;
              reg_wr_addr <= aw_addr_cur[REG_ADDR_WIDTH-1:0];
              reg_wr_data <= w_data_cur;
            end else begin
              state          <= WR_RESP;
              s_axil.b_valid <= 1'b1;
              s_axil.b_resp  <= RESP_DECERR;
            end
          end else if (grant_rd) begin
            if (addr_in_window(ar_addr_cur, REG_ADDR_WIDTH)) begin
              state       <= RD_ACC;
              reg_rd_en   <= 1'b1;
              reg_rd_addr <= ar_addr_cur[REG_ADDR_WIDTH-1:0];
            end else begin
              state          <= RD_RESP;
              s_axil.r_valid <= 1'b1;
              s_axil.r_resp  <= RESP_DECERR;
              s_axil.r_data  <= '0;
            end
          end
        end
        WR_ACC: begin
          reg_wr_en <= 1'b0;
          if (reg_wr_ack) begin
            state          <= WR_RESP;
            s_axil.b_valid <= 1'b1;
            s_axil.b_resp  <= RESP_OKAY;
          end else if (timer_expired) begin
            state          <= WR_RESP;
            s_axil.b_valid <= 1'b1;
            s_axil.b_resp  <= RESP_SLVERR;
          end
        end
        WR_RESP: begin
          if (s_axil.b_ready) begin
            state          <= IDLE;
            s_axil.b_valid <= 1'b0;
          end
        end
        RD_ACC: begin
          reg_rd_en <= 1'b0;
          if (reg_rd_ack) begin
            state          <= RD_RESP;
            s_axil.r_valid <= 1'b1;
            s_axil.r_resp  <= RESP_OKAY;
            s_axil.r_data  <= reg_rd_data;
          end else if (timer_expired) begin
            state          <= RD_RESP;
            s_axil.r_valid <= 1'b1;
            s_axil.r_resp  <= RESP_SLVERR;
            s_axil.r_data  <= '0;
          end
        end
        RD_RESP: begin
          if (s_axil.r_ready) begin
            state          <= IDLE;
            s_axil.r_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_if_reg_bridge.sv
// Directed plus randomized bench for axi_lite_if_reg_bridge with a register-file reference model
// and a variable-latency register responder; timeout checks run when AXIL_REG_TIMEOUT_EN is defined.
module tb_axi_lite_if_reg_bridge;

  localparam int RAW = 12;
  localparam int TOC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            reg_wr_en, reg_rd_en, reg_wr_ack, reg_rd_ack;
  logic [RAW-1:0]  reg_wr_addr, reg_rd_addr;
  logic [31:0]     reg_wr_data, reg_rd_data;

  axi_lite_if bus();

  axi_lite_if_reg_bridge #(.REG_ADDR_WIDTH(RAW), .TIMEOUT_CYCLES(TOC)) dut (
    .axil_aclk   (clk),
    .axil_rst    (rst),
    .s_axil      (bus),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_ack  (reg_wr_ack),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .reg_rd_ack  (reg_rd_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  // Stimulus-side reference register file and responder-side device register file.
  logic [31:0] model_regs [1024];
  logic [31:0] dev_regs [1024];
  int wr_lat = 0, rd_lat = 0, spur_req = 0;
  int wr_pend = 0, rd_pend = 0, rd_idx = 0, spur_seen = 0;
  int wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  logic [31:0] last_wr_data;
  logic [RAW-1:0] last_wr_addr;

  initial begin
    reg_wr_ack = 1'b0;
    reg_rd_ack = 1'b0;
    reg_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      reg_wr_ack = 1'b0;
      reg_rd_ack = 1'b0;
      reg_rd_data = $urandom;
      if (rst) begin
        wr_pend = 0;
        rd_pend = 0;
      end
      if (wr_pend > 0) begin
        wr_pend--;
        if (wr_pend == 0) reg_wr_ack = 1'b1;
      end
      if (rd_pend > 0) begin
        rd_pend--;
        if (rd_pend == 0) begin
          reg_rd_ack = 1'b1;
          reg_rd_data = dev_regs[rd_idx];
        end
      end
      if (reg_wr_en) begin
        wr_cnt++;
        last_wr_addr = reg_wr_addr;
        last_wr_data = reg_wr_data;
        last_wr_cyc = cyc;
        dev_regs[reg_wr_addr[RAW-1:2]] = reg_wr_data;
        if (wr_lat == 0) reg_wr_ack = 1'b1;
        else if (wr_lat > 0) wr_pend = wr_lat;
      end
      if (reg_rd_en) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        rd_idx = int'(reg_rd_addr[RAW-1:2]);
        if (rd_lat == 0) begin
          reg_rd_ack = 1'b1;
          reg_rd_data = dev_regs[rd_idx];
        end else if (rd_lat > 0) rd_pend = rd_lat;
      end
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        reg_wr_ack = 1'b1;
        reg_rd_ack = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int ad, input int wd,
                           output int hs);
    bit awd = 0, wdn = 0, awf, wf;
    int k = 0;
    while (!(awd && wdn) && k < 60) begin
      bus.aw_valid = !awd && (k >= ad);
      bus.aw_addr  = a;
      bus.w_valid  = !wdn && (k >= wd);
      bus.w_data   = d;
      awf = bus.aw_valid && bus.aw_ready;
      wf  = bus.w_valid && bus.w_ready;
      step();
      k++;
      if (awf) awd = 1;
      if (wf)  wdn = 1;
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    hs = cyc - 1;
    check("write_handshake", 64'(awd && wdn), 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, output int hs);
    bit done = 0, f;
    int k = 0;
    while (!done && k < 60) begin
      bus.ar_valid = 1'b1;
      bus.ar_addr  = a;
      f = bus.ar_ready;
      step();
      k++;
      if (f) done = 1;
    end
    bus.ar_valid = 1'b0;
    hs = cyc - 1;
    check("read_handshake", 64'(done), 64'd1);
  endtask

  task automatic drive_all(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    bit awd = 0, wdn = 0, ard = 0, awf, wf, arf;
    int k = 0;
    while (!(awd && wdn && ard) && k < 60) begin
      bus.aw_valid = !awd; bus.aw_addr = wa;
      bus.w_valid  = !wdn; bus.w_data  = wd;
      bus.ar_valid = !ard; bus.ar_addr = ra;
      awf = bus.aw_valid && bus.aw_ready;
      wf  = bus.w_valid && bus.w_ready;
      arf = bus.ar_valid && bus.ar_ready;
      step();
      k++;
      if (awf) awd = 1;
      if (wf)  wdn = 1;
      if (arf) ard = 1;
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.ar_valid = 1'b0;
    check("all_handshake", 64'(awd && wdn && ard), 64'd1);
  endtask

  task automatic wait_b(output int vc);
    int k = 0;
    while (!bus.b_valid && k < 60) begin step(); k++; end
    vc = cyc;
    check("b_valid_seen", 64'(bus.b_valid), 64'd1);
  endtask

  task automatic wait_r(output int vc);
    int k = 0;
    while (!bus.r_valid && k < 60) begin step(); k++; end
    vc = cyc;
    check("r_valid_seen", 64'(bus.r_valid), 64'd1);
  endtask

  task automatic take_b(output logic [1:0] resp);
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
  endtask

  task automatic take_r(output logic [1:0] resp, output logic [31:0] data);
    resp = bus.r_resp;
    data = bus.r_data;
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
  endtask

  task automatic pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                      output bit wfirst);
    logic [1:0] bresp, rresp;
    logic [31:0] data;
    int k = 0, vc;
    drive_all(wa, wd, ra);
    while (!bus.b_valid && !bus.r_valid && k < 60) begin step(); k++; end
    wfirst = bus.b_valid;
    if (wfirst) begin
      take_b(bresp);
      wait_r(vc);
      take_r(rresp, data);
    end else begin
      take_r(rresp, data);
      wait_b(vc);
      take_b(bresp);
    end
    check("rr_b_resp", 64'(bresp), 64'd0);
    check("rr_r_resp", 64'(rresp), 64'd0);
    check("rr_r_data", 64'(data), 64'(model_regs[ra[RAW-1:2]]));
    model_regs[wa[RAW-1:2]] = wd;
  endtask

  initial begin
    int hs, vc, c0;
    logic [1:0] resp;
    logic [31:0] data, a, d;
    bit wfirst, is_wr, oob;

    for (int i = 0; i < 1024; i++) begin
      model_regs[i] = '0;
      dev_regs[i] = '0;
    end
    rst = 1'b1;
    bus.aw_valid = 0; bus.aw_addr = 0; bus.w_valid = 0; bus.w_data = 0; bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_addr = 0; bus.r_ready = 0;
    repeat (3) step();

    check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_strobes", 64'({reg_wr_en, reg_rd_en}), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 64'b111);

    // Same-cycle AW/W with same-cycle ack: minimum latency.
    wr_lat = 0;
    c0 = wr_cnt;
    axi_write(32'h010, 32'hCAFE0001, 0, 0, hs);
    check("t1_strobe", 64'(reg_wr_en), 64'd1);
    check("t1_addr", 64'(reg_wr_addr), 64'h010);
    check("t1_data", 64'(reg_wr_data), 64'hCAFE0001);
    wait_b(vc);
    check("t1_b_latency", 64'(vc - hs), 64'd2);
    take_b(resp);
    check("t1_b_resp", 64'(resp), 64'd0);
    check("t1_strobe_count", 64'(wr_cnt - c0), 64'd1);
    model_regs[32'h010 >> 2] = 32'hCAFE0001;

    // W three cycles ahead of AW, ack four cycles after strobe.
    wr_lat = 4;
    c0 = wr_cnt;
    axi_write(32'h020, 32'h5, 3, 0, hs);
    wait_b(vc);
    take_b(resp);
    check("t2_b_resp", 64'(resp), 64'd0);
    check("t2_strobe_count", 64'(wr_cnt - c0), 64'd1);
    check("t2_ack_latency", 64'(vc - last_wr_cyc), 64'd5);
    check("t2_data", 64'({last_wr_addr, last_wr_data}), {32'h020, 32'h5});
    model_regs[32'h020 >> 2] = 32'h5;

    // Read blocked behind an unaccepted write response.
    wr_lat = 0;
    rd_lat = 2;
    axi_write(32'h004, 32'h1234, 0, 0, hs);
    wait_b(vc);
    take_b(resp);
    model_regs[1] = 32'h1234;
    axi_write(32'h030, 32'hA5A5_5A5A, 1, 0, hs);
    wait_b(vc);
    c0 = rd_cnt;
    axi_read(32'h004, hs);
    repeat (6) step();
    check("t3_read_blocked", 64'(rd_cnt - c0), 64'd0);
    check("t3_b_held", 64'({bus.b_valid, bus.b_resp}), 64'b100);
    take_b(resp);
    model_regs[32'h030 >> 2] = 32'hA5A5_5A5A;
    wait_r(vc);
    take_r(resp, data);
    check("t3_r_resp", 64'(resp), 64'd0);
    check("t3_r_data", 64'(data), 64'h1234);

    // Acks with no access in flight must not produce responses.
    spur_req++;
    repeat (4) step();
    check("spur_no_resp", 64'({bus.b_valid, bus.r_valid}), 64'd0);

    // Out-of-window addresses.
    c0 = rd_cnt;
    axi_read(32'h0001_0000, hs);
    wait_r(vc);
    take_r(resp, data);
    check("t5_r_resp", 64'(resp), 64'd3);
    check("t5_r_data", 64'(data), 64'd0);
    check("t5_no_rd_strobe", 64'(rd_cnt - c0), 64'd0);
    c0 = wr_cnt;
    axi_write(32'h8000_0100, 32'hDEAD_BEEF, 0, 2, hs);
    wait_b(vc);
    take_b(resp);
    check("t5_b_resp", 64'(resp), 64'd3);
    check("t5_no_wr_strobe", 64'(wr_cnt - c0), 64'd0);

    // Randomized traffic against the reference register file.
    for (int n = 0; n < 24; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      oob = ($urandom_range(0, 5) == 0);
      a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if (oob) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
      wr_lat = $urandom_range(0, 3);
      rd_lat = $urandom_range(0, 3);
      if (is_wr) begin
        d = $urandom;
        c0 = wr_cnt;
        axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), hs);
        wait_b(vc);
        take_b(resp);
        check("rand_b_resp", 64'(resp), oob ? 64'd3 : 64'd0);
        check("rand_wr_count", 64'(wr_cnt - c0), oob ? 64'd0 : 64'd1);
        if (!oob) model_regs[a[RAW-1:2]] = d;
      end else begin
        axi_read(a, hs);
        wait_r(vc);
        take_r(resp, data);
        check("rand_r_resp", 64'(resp), oob ? 64'd3 : 64'd0);
        check("rand_r_data", 64'(data), oob ? 64'd0 : 64'(model_regs[a[RAW-1:2]]));
      end
    end

`ifdef AXIL_REG_TIMEOUT_EN
    // Read never acknowledged: SLVERR TOC cycles after the strobe, late ack ignored.
    rd_lat = -1;
    axi_read(32'h00C, hs);
    wait_r(vc);
    check("to_latency", 64'(vc - last_rd_cyc), 64'(TOC));
    take_r(resp, data);
    check("to_r_resp", 64'(resp), 64'd2);
    check("to_r_data", 64'(data), 64'd0);
    spur_req++;
    repeat (4) step();
    check("to_late_ack", 64'(bus.r_valid), 64'd0);
`endif

    // Reset while a read is waiting for its ack.
    rd_lat = -1;
    c0 = rd_cnt;
    axi_read(32'h008, hs);
    repeat (3) step();
    check("mid_rst_strobe", 64'(rd_cnt - c0), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          64'({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid,
               reg_wr_en, reg_rd_en}), 64'd0);
    check("mid_rst_addr", 64'({reg_rd_addr, reg_wr_addr}), 64'd0);
    check("mid_rst_data", 64'({bus.r_data, bus.r_resp, bus.b_resp}), 64'd0);
    step();
    rst = 1'b0;
    rd_lat = 0;
    wr_lat = 0;
    step();
    check("post_rst_ready", 64'(bus.ar_ready), 64'd1);
    repeat (5) step();
    check("post_rst_no_resp", 64'({bus.r_valid, bus.b_valid}), 64'd0);

    // Contended arbitration after reset: write, then read, then write again.
    pair(32'h040, 32'h1111_0001, 32'h004, wfirst);
    check("rr_round1_write_first", 64'(wfirst), 64'd1);
    pair(32'h044, 32'h2222_0002, 32'h010, wfirst);
    check("rr_round2_read_first", 64'(wfirst), 64'd0);
    pair(32'h048, 32'h3333_0003, 32'h040, wfirst);
    check("rr_round3_write_first", 64'(wfirst), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
